uart_cmd_wrapper: RTL and testbench

- Serial front end for the command path.
- Receives 3-byte command frames from the remote over UART (cmd, data high, data low) and presents them as cmd[7:0] / data[15:0] with a held cmd_rdy flag for the command-config stage.
- Serialises the one-byte response (typically 0xA5) back to the remote on send_resp.
- Sits directly upstream of the command-config block.

---
 rtl/uart_cmd_pkg.sv | 19 +
 rtl/uart_cmd_wrapper_if.sv | 35 +++
 rtl/uart_rx.sv | 95 +++++++++
 rtl/uart_cmd_wrapper.sv | 186 ++++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types and constants for the UART command front end.
//   asm_state_t : frame assembly states (cmd byte, data high, data low)
//   tx_state_t  : response transmitter states
//   rx_state_t  : receive bit engine states
//   BAUD_DIV_DEF: default clocks per bit (50 MHz / 19200 baud)
//   FRAME_BYTES : bytes per command frame (cmd + 16-bit data)
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

   typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} asm_state_t;
   typedef enum logic       {TX_IDLE, XMIT}          tx_state_t;
   typedef enum logic       {RX_IDLE, RX_BUSY}       rx_state_t;

   localparam int BAUD_DIV_DEF = 2604;
   localparam int FRAME_BYTES  = 3;

endpackage

// File: rtl/uart_cmd_wrapper_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_wrapper_if
// Command/response handshake between the UART front end and the
// command-config stage.
//   cmd_rdy     : complete frame held on cmd/data
//   cmd         : command opcode (frame byte 1)
//   data        : {frame byte 2, frame byte 3}
//   clr_cmd_rdy : consumer acknowledge, clears cmd_rdy
//   resp        : response byte to transmit
//   send_resp   : one-cycle request to transmit resp
//   resp_sent   : one-cycle pulse when the response stop bit completes
// master = UART front end, slave = command consumer.
// -----------------------------------------------------------------------------
interface uart_cmd_wrapper_if;
   import uart_cmd_pkg::*;

   logic                           cmd_rdy;
   logic [7:0]                     cmd;
   logic [8*(FRAME_BYTES-1)-1:0]   data;
   logic                           clr_cmd_rdy;
   logic [7:0]                     resp;
   logic                           send_resp;
   logic                           resp_sent;

   modport master (
      output cmd_rdy, cmd, data, resp_sent,
      input  clr_cmd_rdy, resp, send_resp
   );

   modport slave (
      input  cmd_rdy, cmd, data, resp_sent,
      output clr_cmd_rdy, resp, send_resp
   );

endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver: 2-flop synchroniser, start-edge detect, mid-bit
// sampling. Delivers each good byte as a one-cycle rx_rdy pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : asynchronous serial input, idles high
//   rx_data    : received byte, valid with rx_rdy
//   rx_rdy     : one-cycle strobe after a good stop bit
// A byte whose stop sample is 0 is dropped; a start bit that is no longer
// low at mid-bit is treated as a glitch.
// -----------------------------------------------------------------------------
module uart_rx
   import uart_cmd_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_rdy
);

   localparam int              CNT_W = $clog2(BAUD_DIV + 1);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(BAUD_DIV / 2);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(BAUD_DIV);

   rx_state_t        state, state_nxt;
   logic             rx_sync_p0, rx_sync_p1, rx_sync_p2;
   logic [CNT_W-1:0] baud_cnt;
   logic [3:0]       bit_idx;
   logic [7:0]       shreg;
   logic             start_det;
   logic             tick;

   // p1 is the synchronised line, p2 its previous value for edge detect
   assign start_det = rx_sync_p2 & ~rx_sync_p1;
   // counter counts down to 1: BAUD_DIV/2 clocks to mid start bit, then
   // BAUD_DIV clocks to each following mid-bit
   assign tick      = (baud_cnt == CNT_W'(1));

   always_comb begin
      state_nxt = state;
      case (state)
         RX_IDLE: if (start_det) state_nxt = RX_BUSY;
         RX_BUSY: begin
            if (tick && (((bit_idx == 4'd0) && rx_sync_p1) || (bit_idx == 4'd9)))
               state_nxt = RX_IDLE;
         end
         default: state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RX_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
         rx_sync_p2 <= 1'b1;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         rx_data    <= '0;
         rx_rdy     <= 1'b0;
      end else begin
         // stage p0 -> p1 -> p2: metastability filter then edge history
         rx_sync_p0 <= rx;
         rx_sync_p1 <= rx_sync_p0;
         rx_sync_p2 <= rx_sync_p1;
         rx_rdy     <= 1'b0;
         if (state == RX_IDLE) begin
            if (start_det) begin
               baud_cnt <= HALF;
               bit_idx  <= '0;
            end
         end else if (tick) begin
            baud_cnt <= FULL;
            bit_idx  <= bit_idx + 4'd1;
            if ((bit_idx >= 4'd1) && (bit_idx <= 4'd8))
               shreg <= {rx_sync_p1, shreg[7:1]};
            if ((bit_idx == 4'd9) && rx_sync_p1) begin
               rx_data <= shreg;
               rx_rdy  <= 1'b1;
            end
         end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// -----------------------------------------------------------------------------
// uart_cmd_wrapper
// Serial front end for the command path. Assembles 3-byte frames
// (cmd, data high, data low) from RX into cmd/data with a held cmd_rdy,
// and serialises one response byte onto TX on send_resp.
//   clk, rst_n : clock, asynchronous active-low reset
//   RX         : serial in from remote, idles high
//   TX         : serial out to remote, idles high
//   bus        : uart_cmd_wrapper_if.master (cmd_rdy/cmd/data/clr_cmd_rdy,
//                resp/send_resp/resp_sent)
// Build option CMD_TIMEOUT_EN: adds the TIMEOUT parameter and an inter-byte
// timer that drops a partial frame after TIMEOUT idle clocks, so framing
// recovers after a lost byte. Without it a partial frame waits forever.
// -----------------------------------------------------------------------------
module uart_cmd_wrapper
   import uart_cmd_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEF
`ifdef CMD_TIMEOUT_EN
   ,
   parameter int TIMEOUT  = 2**20
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                RX,
   output logic                TX,
   uart_cmd_wrapper_if.master  bus
);

   localparam int               CNT_W    = $clog2(BAUD_DIV + 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);

   logic [7:0] rx_data;
   logic       rx_rdy;

   uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx      (RX),
      .rx_data (rx_data),
      .rx_rdy  (rx_rdy)
   );

   // ------------------------------------------------------------------
   // Frame assembly
   // ------------------------------------------------------------------
   asm_state_t asm_state, asm_nxt;
   logic [7:0] cmd_shadow, data_hi_shadow;
   logic       frame_start, frame_hi, frame_done;
   logic       to_expire;

`ifdef CMD_TIMEOUT_EN
   localparam int                TO_CNT_W = 20;
   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);
   logic [TO_CNT_W-1:0] to_cnt;

   // runs only while a frame is partially received; any byte restarts it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          to_cnt <= '0;
      else if (rx_rdy || asm_state == IDLE) to_cnt <= '0;
      else                                 to_cnt <= to_cnt + TO_CNT_W'(1);
   end

   assign to_expire = (to_cnt == TO_LAST);
`else
   assign to_expire = 1'b0;
`endif

   always_comb begin
      asm_nxt     = asm_state;
      frame_start = 1'b0;
      frame_hi    = 1'b0;
      frame_done  = 1'b0;
      case (asm_state)
         IDLE: begin
            if (rx_rdy) begin
               frame_start = 1'b1;
               asm_nxt     = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (rx_rdy) begin
               frame_hi = 1'b1;
               asm_nxt  = WAIT_LO;
            end else if (to_expire) begin
               asm_nxt = IDLE;
            end
         end
         WAIT_LO: begin
            if (rx_rdy) begin
               frame_done = 1'b1;
               asm_nxt    = IDLE;
            end else if (to_expire) begin
               asm_nxt = IDLE;
            end
         end
         default: asm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) asm_state <= IDLE;
      else        asm_state <= asm_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_shadow     <= '0;
         data_hi_shadow <= '0;
         bus.cmd        <= '0;
         bus.data       <= '0;
         bus.cmd_rdy    <= 1'b0;
      end else begin
         if (frame_start) cmd_shadow     <= rx_data;
         if (frame_hi)    data_hi_shadow <= rx_data;
         // cmd/data only move on the completing byte so the consumer sees
         // a stable frame for as long as cmd_rdy is high
         if (frame_done) begin
            bus.cmd  <= cmd_shadow;
            bus.data <= {data_hi_shadow, rx_data};
         end
         // set beats clear; a new frame's first byte withdraws the old one
         if (frame_done)
            bus.cmd_rdy <= 1'b1;
         else if (bus.clr_cmd_rdy || frame_start)
            bus.cmd_rdy <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Response transmitter
   // ------------------------------------------------------------------
   tx_state_t        tx_state, tx_nxt;
   logic [9:0]       tx_shreg;
   logic [CNT_W-1:0] tx_baud;
   logic [3:0]       tx_bit;
   logic             tx_bit_end;
   logic             tx_last;

   assign tx_bit_end = (tx_baud == '0);
   assign tx_last    = tx_bit_end && (tx_bit == 4'd9);
   // shift register idles all-ones and back-fills ones, so bit 0 is the
   // line level in every state without a separate output mux
   assign TX         = tx_shreg[0];

   always_comb begin
      tx_nxt = tx_state;
      case (tx_state)
         TX_IDLE: if (bus.send_resp) tx_nxt = XMIT;
         XMIT:    if (tx_last)       tx_nxt = TX_IDLE;
         default: tx_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_state <= TX_IDLE;
      else        tx_state <= tx_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shreg      <= '1;
         tx_baud       <= '0;
         tx_bit        <= '0;
         bus.resp_sent <= 1'b0;
      end else begin
         bus.resp_sent <= 1'b0;
         if (tx_state == TX_IDLE) begin
            if (bus.send_resp) begin
               tx_shreg <= {1'b1, bus.resp, 1'b0};
               tx_baud  <= BIT_LAST;
               tx_bit   <= '0;
            end
         end else if (tx_bit_end) begin
            tx_shreg <= {1'b1, tx_shreg[9:1]};
            tx_baud  <= BIT_LAST;
            tx_bit   <= tx_bit + 4'd1;
            if (tx_bit == 4'd9) bus.resp_sent <= 1'b1;
         end else begin
            tx_baud <= tx_baud - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_wrapper
// Directed bench for uart_cmd_wrapper: reset, frame capture, back-to-back
// frames, framing error, response transmit and inter-byte timeout
// (expectations follow CMD_TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_uart_cmd_wrapper;

   localparam int B = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic RX;
   logic TX;

   uart_cmd_wrapper_if bus ();

   uart_cmd_wrapper #(
      .BAUD_DIV (B)
`ifdef CMD_TIMEOUT_EN
      ,
      .TIMEOUT  (300)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .RX    (RX),
      .TX    (TX),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stopb);
      logic [9:0] fr;
      fr = {stopb, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         RX = fr[i];
         cyc(B);
      end
      RX = 1'b1;
      cyc(B);
   endtask

   // Waits (bounded) for the receiver strobe of the frame's last byte and
   // checks cmd_rdy is low then and high one clock later.
   task automatic wait_frame_done(input string tag, input bit clr_at_set);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12*B && !seen; i++) begin
         @(negedge clk);
         if (dut.u_rx.rx_rdy) seen = 1'b1;
      end
      chk({tag, " rx_rdy seen"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({tag, " cmd_rdy at rx_rdy"}, 32'(bus.cmd_rdy), 32'd0);
         if (clr_at_set) bus.clr_cmd_rdy = 1'b1;
         @(negedge clk);
         bus.clr_cmd_rdy = 1'b0;
         chk({tag, " cmd_rdy next clk"}, 32'(bus.cmd_rdy), 32'd1);
      end
   endtask

   task automatic frame3(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input string tag);
      send_byte(b0, 1'b1);
      send_byte(b1, 1'b1);
      fork
         send_byte(b2, 1'b1);
         wait_frame_done(tag, 1'b0);
      join
   endtask

   task automatic clr_pulse(input string tag);
      bus.clr_cmd_rdy = 1'b1;
      cyc(1);
      bus.clr_cmd_rdy = 1'b0;
      chk({tag, " cmd_rdy cleared"}, 32'(bus.cmd_rdy), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [9:0] txe;
      int         pulses;

      RX              = 1'b1;
      rst_n           = 1'b0;
      bus.clr_cmd_rdy = 1'b0;
      bus.send_resp   = 1'b0;
      bus.resp        = 8'h00;
      cyc(5);
      chk("reset TX",        32'(TX),            32'd1);
      chk("reset cmd_rdy",   32'(bus.cmd_rdy),   32'd0);
      chk("reset cmd",       32'(bus.cmd),       32'h00);
      chk("reset data",      32'(bus.data),      32'h0000);
      chk("reset resp_sent", 32'(bus.resp_sent), 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // load a frame, then reset with TX and RX both mid-flight
      frame3(8'h5A, 8'hC3, 8'h3C, "pre");
      chk("pre cmd",  32'(bus.cmd),  32'h5A);
      chk("pre data", 32'(bus.data), 32'hC33C);
      bus.resp      = 8'h00;
      bus.send_resp = 1'b1;
      cyc(1);
      bus.send_resp = 1'b0;
      RX = 1'b0;
      cyc(2*B);
      chk("tx busy before reset", 32'(TX), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrx reset TX",      32'(TX),          32'd1);
      chk("midrx reset cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
      chk("midrx reset cmd",     32'(bus.cmd),     32'h00);
      chk("midrx reset data",    32'(bus.data),    32'h0000);
      RX = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(2*B);

      // basic frame
      frame3(8'h02, 8'h12, 8'h34, "basic");
      chk("basic cmd",  32'(bus.cmd),  32'h02);
      chk("basic data", 32'(bus.data), 32'h1234);
      cyc(20);
      chk("basic cmd_rdy held", 32'(bus.cmd_rdy), 32'd1);
      clr_pulse("basic");
      chk("basic cmd after clr", 32'(bus.cmd), 32'h02);

      // back-to-back frames without clear
      frame3(8'h05, 8'hFF, 8'h80, "b2b1");
      chk("b2b1 cmd",  32'(bus.cmd),  32'h05);
      chk("b2b1 data", 32'(bus.data), 32'hFF80);
      send_byte(8'h06, 1'b1);
      chk("b2b2 byte1 cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
      chk("b2b2 byte1 cmd",     32'(bus.cmd),     32'h05);
      send_byte(8'h00, 1'b1);
      chk("b2b2 byte2 cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
      fork
         send_byte(8'h01, 1'b1);
         wait_frame_done("b2b2", 1'b0);
      join
      chk("b2b2 cmd",  32'(bus.cmd),  32'h06);
      chk("b2b2 data", 32'(bus.data), 32'h0001);
      clr_pulse("b2b2");

      // framing error on byte 2; clear collides with the set (set wins)
      send_byte(8'h11, 1'b1);
      send_byte(8'h99, 1'b0);
      send_byte(8'hAB, 1'b1);
      fork
         send_byte(8'hCD, 1'b1);
         wait_frame_done("ferr", 1'b1);
      join
      chk("ferr cmd",  32'(bus.cmd),  32'h11);
      chk("ferr data", 32'(bus.data), 32'hABCD);
      clr_pulse("ferr");

      // response transmit, ignored mid-frame request, minimum turnaround
      txe    = {1'b1, 8'hA5, 1'b0};
      pulses = 0;
      bus.resp      = 8'hA5;
      bus.send_resp = 1'b1;
      cyc(1);
      bus.send_resp = 1'b0;
      for (int c = 0; c <= 21*B; c++) begin
         @(negedge clk);
         if (bus.resp_sent) pulses++;
         if ((c < 10*B) && (c % B == B/2))
            chk("tx bit", 32'(TX), 32'(txe[c/B]));
         if (c == 3*B)   bus.send_resp = 1'b1;
         if (c == 3*B+1) bus.send_resp = 1'b0;
         if (c == 10*B-1) chk("resp_sent early", 32'(bus.resp_sent), 32'd0);
         if (c == 10*B) begin
            chk("resp_sent pulse", 32'(bus.resp_sent), 32'd1);
            chk("tx idle after stop", 32'(TX), 32'd1);
         end
         if (c == 10*B+1) begin
            chk("resp_sent one cycle", 32'(bus.resp_sent), 32'd0);
            chk("tx no queued frame", 32'(TX), 32'd1);
            bus.resp      = 8'h3C;
            bus.send_resp = 1'b1;
         end
         if (c == 10*B+2) begin
            bus.send_resp = 1'b0;
            chk("turnaround start bit", 32'(TX), 32'd0);
         end
         if (c == 20*B+2) chk("second resp_sent", 32'(bus.resp_sent), 32'd1);
      end
      chk("resp_sent pulse count", 32'(pulses), 32'd2);

      // inter-byte timeout: lone byte, long idle, then a full frame
      send_byte(8'h02, 1'b1);
      cyc(400);
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      cyc(4);
`ifdef CMD_TIMEOUT_EN
      chk("timeout cmd",     32'(bus.cmd),     32'h03);
      chk("timeout data",    32'(bus.data),    32'h0010);
      chk("timeout cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
`else
      chk("no-timeout cmd",     32'(bus.cmd),     32'h02);
      chk("no-timeout data",    32'(bus.data),    32'h0300);
      chk("no-timeout cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
